// File: rtl/ps2_pkg.sv
// PS/2 receiver shared definitions: frame constants and the frame parity check.
package ps2_pkg;

   localparam int unsigned PS2_FRAME_BITS = 11;
   localparam logic [7:0]  PS2_BREAK_CODE = 8'hF0;
   localparam logic [7:0]  PS2_EXT_CODE   = 8'hE0;

   // Odd parity holds when {D7..D0, P} contains an odd number of ones.
   function automatic logic ps2_odd_parity_ok(input logic [7:0] d, input logic p);
      return ^{d, p};
   endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side handshake of the PS/2 receive FIFO.
// master: the receiver (drives data/status, samples nextdata_n).
// slave:  the consumer (key-state / display logic).
interface ps2_rx_fifo_if;

   logic [7:0] data;
   logic       ready;
   logic       overflow;
   logic       frame_err;
   logic       nextdata_n;

   modport master (
      output data,
      output ready,
      output overflow,
      output frame_err,
      input  nextdata_n
   );

   modport slave (
      input  data,
      input  ready,
      input  overflow,
      input  frame_err,
      output nextdata_n
   );

endinterface

// File: rtl/ps2_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head is read combinationally.
// A push is accepted when not full, or when full and a pop happens in the
// same cycle (the write lands in the slot being vacated).
module ps2_sync_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             pop_ok;
   logic             push_ok;

   // Status flags and accepted-operation qualifiers.
   always_comb begin
      empty   = (wr_ptr == rd_ptr);
      full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
      pop_ok  = pop & ~empty;
      push_ok = push & (~full | pop_ok);
      dout    = mem[rd_ptr[AW-1:0]];
   end

   // Pointer update; pointers wrap modulo 2*DEPTH.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage, cleared on reset so the head reads 0 out of reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push_ok) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host frame receiver feeding a read-side FIFO.
// Optional feature macro: PS2_PARITY_CHECK_EN -- when defined, frames with
// bad odd parity are rejected; otherwise the parity bit is ignored.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 ps2_clk,
   input  logic                 ps2_data,
   ps2_rx_fifo_if.master        bus
);

   localparam int unsigned IW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [3:0]  LAST_BIT = 4'(PS2_FRAME_BITS - 1);
   localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES);

   logic          clk_s1, clk_s2, clk_h;
   logic          dat_s1, dat_s2;
   logic          fall;
   logic [3:0]    bit_cnt;
   logic [9:0]    shreg;
   logic [IW-1:0] idle_cnt;
   logic          par_ok;
   logic          frame_ok;
   logic          push_req;
   logic [7:0]    push_byte;
   logic          frame_err_q;
   logic          ovf_q;
   logic          pop_req;
   logic          fifo_empty;
   logic          fifo_full;
   logic [7:0]    fifo_dout;

   // Two-flop synchronisers plus a history flop on the PS/2 clock.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         clk_h  <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         clk_h  <= clk_s2;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
      end
   end

   // Edge detect and frame check; shreg holds start..parity when the stop
   // bit (current dat_s2) arrives.
   always_comb begin
      fall   = clk_h & ~clk_s2;
      par_ok = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
      par_ok = ps2_odd_parity_ok(shreg[8:1], shreg[9]);
`endif
      frame_ok = ~shreg[0] & dat_s2 & par_ok;
   end

   // Bit shifting, frame completion and mid-frame idle timeout.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt     <= '0;
         shreg       <= '0;
         idle_cnt    <= '0;
         push_req    <= 1'b0;
         push_byte   <= '0;
         frame_err_q <= 1'b0;
      end else begin
         push_req    <= 1'b0;
         frame_err_q <= 1'b0;
         if (fall) begin
            idle_cnt <= '0;
            shreg    <= {dat_s2, shreg[9:1]};
            if (bit_cnt == LAST_BIT) begin
               bit_cnt     <= '0;
               push_req    <= frame_ok;
               frame_err_q <= ~frame_ok;
               push_byte   <= shreg[8:1];
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else if (bit_cnt != '0) begin
            if (idle_cnt == IDLE_MAX) begin
               bit_cnt  <= '0;
               idle_cnt <= '0;
            end else begin
               idle_cnt <= idle_cnt + IW'(1);
            end
         end else begin
            idle_cnt <= '0;
         end
      end
   end

   assign pop_req = ~bus.nextdata_n & ~fifo_empty;

   // Sticky overflow: set on a dropped push, cleared by a pop; set wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf_q <= 1'b0;
      end else if (push_req && fifo_full && !pop_req) begin
         ovf_q <= 1'b1;
      end else if (pop_req) begin
         ovf_q <= 1'b0;
      end
   end

   ps2_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_req),
      .pop     (pop_req),
      .din     (push_byte),
      .dout    (fifo_dout),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   assign bus.data      = fifo_dout;
   assign bus.ready     = ~fifo_empty;
   assign bus.overflow  = ovf_q;
   assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: frames are bit-banged on the PS/2 pins,
// accepted bytes are queued as expected, and a monitor checks every pop.
module tb_ps2_rx_fifo;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned TMO   = 300;
   localparam int unsigned HP    = 8;

   logic clk      = 1'b0;
   logic reset_n  = 1'b0;
   logic ps2_clk  = 1'b1;
   logic ps2_data = 1'b1;
   logic nd_man   = 1'b1;
   logic nd_rand  = 1'b1;
   logic cons_en  = 1'b0;

   ps2_rx_fifo_if bus();
   assign bus.nextdata_n = cons_en ? nd_rand : nd_man;

   ps2_rx_fifo #(
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int         n_pass  = 0;
   int         n_total = 0;
   int         exp_err = 0;
   int         err_seen = 0;
   logic       fe_prev = 1'b0;
   logic [7:0] exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Monitor: compare every pop against the scoreboard; frame_err is one cycle.
   always @(negedge clk) begin
      if (reset_n) begin
         if (bus.ready && !bus.nextdata_n) begin
            if (exp_q.size() > 0) chk("sb_data", {24'h0, bus.data}, {24'h0, exp_q.pop_front()});
            else chk("sb_unexpected", {24'h0, bus.data}, 32'hFFFF_FFFF);
         end
         if (bus.frame_err) begin
            err_seen++;
            chk("err_width", {31'h0, fe_prev}, 32'h0);
         end
         fe_prev = bus.frame_err;
      end else begin
         fe_prev = 1'b0;
      end
   end

   // Random consumer, pops roughly two cycles out of three when enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1 nd_rand = ($urandom_range(0, 2) == 0);
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic ps2_bit(input logic b);
      @(posedge clk);
      #1 ps2_data = b;
      repeat (HP) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (HP) @(posedge clk);
      #1 ps2_clk = 1'b1;
   endtask

   task automatic send_partial(input int n);
      for (int i = 0; i < n; i++) ps2_bit(1'($urandom_range(0, 1)));
      ps2_data = 1'b1;
   endtask

   // kind: 0 good, 1 bad start, 2 bad stop, 3 bad parity.
   // mode: 0 plain, 1 check push latency, 2 pop in the same cycle as the push.
   task automatic send_frame(input logic [7:0] b, input int kind, input int mode);
      logic [10:0] fr;
      logic        good;
      fr[0]    = (kind == 1);
      fr[8:1]  = b;
      fr[9]    = (~^b) ^ (kind == 3);
      fr[10]   = (kind != 2);
      good     = (kind == 0);
`ifndef PS2_PARITY_CHECK_EN
      if (kind == 3) good = 1'b1;
`endif
      for (int i = 0; i < 10; i++) ps2_bit(fr[i]);
      @(posedge clk);
      #1 ps2_data = fr[10];
      repeat (HP) @(posedge clk);
      #1 ps2_clk = 1'b0;
      if (good) begin
         if (mode == 2 || exp_q.size() < DEPTH) exp_q.push_back(b);
      end else begin
         exp_err++;
      end
      repeat (3) @(posedge clk);
      #1;
      if (mode == 1) chk("lat_before", {31'h0, bus.ready}, 32'h0);
      if (mode == 2) nd_man = 1'b0;
      @(posedge clk);
      #1;
      if (mode == 1) begin
         chk("lat_ready", {31'h0, bus.ready}, 32'h1);
         chk("lat_data", {24'h0, bus.data}, {24'h0, b});
      end
      if (mode == 2) begin
         nd_man = 1'b1;
         chk("simul_ovf", {31'h0, bus.overflow}, 32'h0);
      end
      repeat (HP - 4) @(posedge clk);
      #1 ps2_clk = 1'b1;
      ps2_data = 1'b1;
      repeat (4 * HP) @(posedge clk);
   endtask

   task automatic pop_for(input int n);
      @(posedge clk);
      #1 nd_man = 1'b0;
      repeat (n) @(posedge clk);
      #1 nd_man = 1'b1;
   endtask

   initial begin
      logic exp_par_ready;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'h0, bus.ready}, 32'h0);
      chk("rst_ovf",   {31'h0, bus.overflow}, 32'h0);
      chk("rst_err",   {31'h0, bus.frame_err}, 32'h0);
      chk("rst_data",  {24'h0, bus.data}, 32'h0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (5) @(posedge clk);

      // Single byte with latency check, then a one-cycle pop
      send_frame(8'h1C, 0, 1);
      pop_for(1);
      chk("single_empty", {31'h0, bus.ready}, 32'h0);

      // Overflow: nine frames without popping
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0);
      @(negedge clk);
      chk("ovf_set",  {31'h0, bus.overflow}, 32'h1);
      chk("ovf_head", {24'h0, bus.data}, 32'h01);
      @(posedge clk);
      #1 nd_man = 1'b0;
      @(posedge clk);
      #1 chk("ovf_clear", {31'h0, bus.overflow}, 32'h0);
      repeat (9) @(posedge clk);
      #1 nd_man = 1'b1;
      chk("ovf_drained", {31'h0, bus.ready}, 32'h0);

      // Bad parity
      send_frame(8'h1C, 3, 0);
`ifdef PS2_PARITY_CHECK_EN
      exp_par_ready = 1'b0;
`else
      exp_par_ready = 1'b1;
`endif
      @(negedge clk);
      chk("par_ready", {31'h0, bus.ready}, {31'h0, exp_par_ready});
      pop_for(2);
      chk("par_err_count", err_seen, exp_err);

      // Timeout discards a partial frame silently
      send_partial(4);
      repeat (TMO + 10) @(posedge clk);
      send_frame(8'hF0, 0, 0);
      @(negedge clk);
      chk("tmo_ready", {31'h0, bus.ready}, 32'h1);
      chk("tmo_data",  {24'h0, bus.data}, 32'hF0);
      chk("tmo_err",   err_seen, exp_err);
      pop_for(1);
      chk("tmo_one_byte", {31'h0, bus.ready}, 32'h0);

      // Full FIFO with a push and pop in the same cycle
      for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i), 0, 0);
      send_frame(8'h18, 0, 2);
      pop_for(10);
      chk("simul_drained", {31'h0, bus.ready}, 32'h0);
      chk("simul_ovf_end", {31'h0, bus.overflow}, 32'h0);

      // Reset in the middle of a frame
      send_partial(5);
      @(posedge clk);
      #1 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("mrst_ready", {31'h0, bus.ready}, 32'h0);
      chk("mrst_ovf",   {31'h0, bus.overflow}, 32'h0);
      chk("mrst_err",   {31'h0, bus.frame_err}, 32'h0);
      chk("mrst_data",  {24'h0, bus.data}, 32'h0);
      exp_q.delete();
      @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (4 * HP) @(posedge clk);
      send_frame(8'h5A, 0, 0);
      @(negedge clk);
      chk("mrst_rx_data", {24'h0, bus.data}, 32'h5A);
      pop_for(2);
      chk("mrst_one_byte", {31'h0, bus.ready}, 32'h0);

      // Random traffic with a random consumer
      cons_en = 1'b1;
      for (int i = 0; i < 30; i++) begin
         int r;
         int kind;
         r = $urandom_range(0, 9);
         kind = (r < 3) ? r + 1 : 0;
         send_frame(8'($urandom), kind, 0);
      end
      for (int i = 0; i < 500 && (exp_q.size() != 0 || bus.ready); i++) @(posedge clk);
      cons_en = 1'b0;
      @(negedge clk);
      chk("rand_drain", exp_q.size(), 32'h0);
      chk("rand_ready", {31'h0, bus.ready}, 32'h0);
      chk("err_count", err_seen, exp_err);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

PS/2 device-to-host frame receiver with a read-side FIFO. It samples the keyboard's `ps2_clk`/`ps2_data` lines in the system clock domain and validates each 11-bit frame. Accepted scan-code bytes are pushed into a small FIFO. The block sits directly upstream of the key-state / display logic, which consumes bytes through the `ready` / `nextdata_n` handshake.

## Interface
- `FIFO_DEPTH`, default 8: number of FIFO entries; must be a power of two, minimum 2.
- `TIMEOUT_CYCLES`, default 50000: number of `clk` cycles with `ps2_clk` idle high in mid-frame before the partial frame is discarded.
- `clk`, input, 1: system clock; all logic is on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `ps2_clk`, input, 1: raw PS/2 clock line; asynchronous to `clk`.
- `ps2_data`, input, 1: raw PS/2 data line; asynchronous to `clk`.
- `nextdata_n`, input, 1: active-low pop request, sampled on `clk`.
- `data`, output, 8: byte at the FIFO head; valid while `ready` is 1.
- `ready`, output, 1: FIFO is non-empty.
- `overflow`, output, 1: sticky flag; a frame was dropped because the FIFO was full.
- `frame_err`, output, 1: one-cycle pulse when a received frame is rejected.

## Operation
- **Synchronisation:** `ps2_clk` and `ps2_data` each pass through 2 flops, then a third history flop on `ps2_clk`. A falling edge is history=1, synced=0. Data is sampled from the synchronised `ps2_data` in the same cycle the edge is detected.
- **Frame format:** start bit (0), D0..D7 LSB first, odd parity, stop bit (1). The shift register is 10 bits wide; the bit counter runs 0..10.
- **Bit counter:**
  - Increments on each detected falling edge.
  - On the edge where the counter is 10, the frame is complete and checked; the counter returns to 0.
- **Frame checks:**
  - Start must be 0 and stop must be 1.
  - Parity is checked per Configuration.
  - Fail: no push, `frame_err` = 1 for one cycle.
  - Pass: push D7..D0.
- **Timeout:** an idle counter resets on every falling edge and counts while the counter is non-zero. When it reaches `TIMEOUT_CYCLES`, the bit counter clears silently (no `frame_err`).
- **FIFO:**
  - Read and write pointers are log2(`FIFO_DEPTH`)+1 bits wide and wrap modulo 2·`FIFO_DEPTH`.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
- **Pop:** occurs on a `clk` edge with `nextdata_n`=0 and `ready`=1. A pop while empty is ignored.
- **Push while full, no pop in the same cycle:** the byte is dropped and `overflow` is set to 1.
- **Push and pop in the same cycle:** both take effect, even when full; `overflow` is not set.
- **`overflow` clearing:** cleared on the first successful pop after it was set. A set and a clear in the same cycle resolve to set.
- **Reset values:** pointers 0, shift register 0, bit counter 0, idle counter 0, sync flops 1. This gives `ready`=0, `overflow`=0, `frame_err`=0, `data`=8'h00 (RAM is cleared on reset).

## Timing
- **Pin to edge detect:** an edge on the `ps2_clk` pin is detected 3 `clk` cycles later.
- **Push latency:** the FIFO write happens on the `clk` edge after the stop-bit falling edge is detected. `ready` and `data` are valid from that edge (registered pointers, combinational head read).
- **Pop latency:** the pop takes effect on the sampling edge. The next byte appears on `data` in the following cycle, or `ready` falls if the FIFO is now empty.
- **Back-to-back pops:** holding `nextdata_n` low for N cycles pops min(N, count) bytes.
- **Reset during a frame:** `reset_n` low mid-frame aborts the frame immediately. After release, reception restarts at the next start bit; the first falling edge after release counts as bit 0.

## Configuration
- **`PS2_PARITY_CHECK_EN` defined:** the odd-parity bit is checked. A mismatch rejects the frame (no push, `frame_err` pulse).
- **`PS2_PARITY_CHECK_EN` undefined:** the parity bit is shifted in but ignored; only start/stop errors assert `frame_err`.

## Structure
- **Shared package `ps2_pkg`:**
  - Constants: `PS2_FRAME_BITS`=11, `PS2_BREAK_CODE`=8'hF0, `PS2_EXT_CODE`=8'hE0.
  - Frame-check function: odd parity over {D7..D0, P}.
- **Sub-module `ps2_sync_fifo`:** the parameterised single-clock FIFO (push, pop, head, empty, full). The frame receiver stays in `ps2_rx_fifo`.

## Test plan
- **Single byte:** send frame 0x1C (parity 0, stop 1), then hold `nextdata_n`=1.
  - Required: `ready`=1 and `data`=8'h1C from 1 cycle after the stop edge.
  - Then pulse `nextdata_n`=0 for one cycle: `ready`=0 the next cycle.
- **Overflow:** send 0x01..0x09 without popping.
  - After the 9th frame: `overflow`=1, FIFO holds 0x01..0x08.
  - Then 8 pops return 0x01..0x08 in order; `overflow`=0 after the first pop.
- **Bad parity (`PS2_PARITY_CHECK_EN` defined):** send 0x1C with parity=1.
  - Required: one-cycle `frame_err`, `ready` stays 0.
  - The same stimulus with the macro undefined: 0x1C pushed, no `frame_err`.
- **Timeout:** send 4 bits, then hold `ps2_clk` high for `TIMEOUT_CYCLES`+10 cycles, then send a full 0xF0 frame.
  - Required: exactly one byte 8'hF0 in the FIFO, no `frame_err`.
- **Full with simultaneous push and pop:** fill 8 entries (0x10..0x17), then time a pop to the same cycle as the 0x18 push.
  - Required: `overflow`=0; subsequent pops return 0x11..0x18.
- **Reset mid-frame:** assert `reset_n`=0 after 5 bits, release, then send 0x5A.
  - Required: all outputs 0 during reset; afterwards exactly 0x5A is received.
